wb_mailbox: RTL and testbench
=============================

WB_MAILBOX -- requirements
Module: wb_mailbox

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving FIFO entries per direction; a power of two, 2..16.
REQ-002 The block SHALL have parameter DW, default 32, giving data width of the Wishbone bus and both streams.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  system clock, all state on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset (driven from caravel_wb_rst_i).
REQ-006 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle and write-enable.
REQ-007 wbs_sel_i  in  4  byte selects; wbs_adr_i  in  DW  byte address, only bits [3:2] decoded.
REQ-008 wbs_dat_i  in  DW  write data; wbs_dat_o  out  DW  read data; wbs_ack_o  out  1  acknowledge.
REQ-009 h2s_data_o  out  DW, h2s_valid_o  out  1, h2s_ready_i  in  1  host-to-SoC stream, SoC pops.
REQ-010 s2h_data_i  in  DW, s2h_valid_i  in  1, s2h_ready_o  out  1  SoC-to-host stream, SoC pushes.
REQ-011 irq_o  out  1  level interrupt to the Caravel user_irq line.

Function
REQ-012 Register map: 0x0 DATA, 0x4 STATUS, 0x8 IRQ_EN, 0xC reserved (reads 0, writes ignored).
REQ-013 Bus FSM SHALL have states IDLE and ACK; IDLE->ACK when stb&cyc; ACK->IDLE unconditionally.
REQ-014 wbs_ack_o SHALL be high only in ACK: one cycle, one clock after request; never two acks back to back.
REQ-015 All register side effects (push, pop, writes) SHALL occur on the clock edge ending the ACK cycle, exactly once per transaction.
REQ-016 wbs_dat_o SHALL be valid during ACK and 0 in all other cycles.
REQ-017 DATA write: push wbs_dat_i into H2S FIFO if not full; if full, data dropped and STATUS.h2s_ovf set.
REQ-018 DATA read: return S2H head and pop; if S2H empty, return 0, no pop, set STATUS.s2h_udf.
REQ-019 STATUS read: [0] h2s_full, [1] h2s_empty, [2] s2h_full, [3] s2h_empty, [4] h2s_ovf, [5] s2h_udf, [12:8] h2s count, [20:16] s2h count, others 0.
REQ-020 STATUS write: writing 1 to bit 4 or 5 clears that sticky flag (W1C); other bits ignored; applies only when wbs_sel_i[0]=1.
REQ-021 IRQ_EN: bit0 R/W, written only when wbs_sel_i[0]=1; other bits read 0.
REQ-022 h2s_valid_o = !h2s_empty; h2s_data_o = H2S head; pop on h2s_valid_o & h2s_ready_i.
REQ-023 s2h_ready_o = !s2h_full; push s2h_data_i on s2h_valid_i & s2h_ready_o.
REQ-024 Full/empty SHALL come from registered state: no fall-through (pushed word visible next cycle), push into a full FIFO rejected even with a same-cycle pop.
REQ-025 Simultaneous push and pop on a non-full, non-empty FIFO SHALL both succeed, count unchanged.
REQ-026 Pointers SHALL wrap modulo DEPTH; counts range 0..DEPTH.
REQ-027 irq_o SHALL be registered: irq_o(next) = IRQ_EN[0] & !s2h_empty.
REQ-028 A request dropping stb/cyc during ACK SHALL still complete the side effect (classic single-cycle, no abort).

Reset
REQ-029 On rst_i=1 at a clock edge: FSM->IDLE, both FIFOs empty, pointers 0, sticky flags 0, IRQ_EN 0.
REQ-030 During and after reset: wbs_ack_o=0, wbs_dat_o=0, h2s_valid_o=0, s2h_ready_o=1, irq_o=0; FIFO contents need no reset.
REQ-031 Reset asserted during ACK SHALL cancel that transaction: no push/pop, ack low next cycle.

Verification
REQ-032 Write DATA 0xA5A5_0001, hold h2s_ready_i=0 -> ack one cycle after stb, h2s_valid_o=1 next cycle, h2s_data_o=0xA5A5_0001, STATUS[12:8]=1.
REQ-033 Nine DATA writes with DEPTH=8, h2s_ready_i=0 -> STATUS[0]=1, STATUS[4]=1, first 8 words drained in order; write 0x10 to STATUS -> STATUS[4]=0.
REQ-034 SoC pushes 0x11,0x22; IRQ_EN=1 -> irq_o=1; two DATA reads return 0x11, 0x22; irq_o=0 one cycle after second pop.
REQ-035 DATA read with S2H empty -> wbs_dat_o=0 during ack, STATUS[5]=1, S2H count stays 0.
REQ-036 S2H at count 4, SoC push and host DATA read on same edge -> count stays 4, read returns oldest word.
REQ-037 rst_i pulsed in ACK of a DATA write -> no push, h2s_empty=1, all outputs at reset values.

Source files
------------

// File: rtl/wb_mailbox.sv
// wb_mailbox: Wishbone-slave mailbox with a host-to-SoC and a SoC-to-host FIFO.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i/sel_i/adr_i   Wishbone classic request (adr bits [3:2] decoded)
//   wbs_dat_i, wbs_dat_o, wbs_ack_o    write data, read data (0 outside ack), acknowledge
//   h2s_data_o/valid_o, h2s_ready_i    host-to-SoC stream, popped by the SoC
//   s2h_data_i/valid_i, s2h_ready_o    SoC-to-host stream, pushed by the SoC
//   irq_o                              registered level interrupt
// Registers: 0x0 DATA, 0x4 STATUS, 0x8 IRQ_EN, 0xC reserved.
module wb_mailbox #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [DW-1:0] wbs_adr_i,
    input  logic [DW-1:0] wbs_dat_i,
    output logic [DW-1:0] wbs_dat_o,
    output logic          wbs_ack_o,
    output logic [DW-1:0] h2s_data_o,
    output logic          h2s_valid_o,
    input  logic          h2s_ready_i,
    input  logic [DW-1:0] s2h_data_i,
    input  logic          s2h_valid_i,
    output logic          s2h_ready_o,
    output logic          irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [1:0]    adr_q, adr_d;
    logic          we_q, we_d, sel0_q, sel0_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [AW-1:0] h2s_wr_q, h2s_wr_d, h2s_rd_q, h2s_rd_d;
    logic [AW-1:0] s2h_wr_q, s2h_wr_d, s2h_rd_q, s2h_rd_d;
    logic [CW-1:0] h2s_cnt_q, h2s_cnt_d, s2h_cnt_q, s2h_cnt_d;
    logic          ovf_q, ovf_d, udf_q, udf_d, irq_en_q, irq_en_d, irq_q, irq_d;
    logic [DW-1:0] h2s_mem [DEPTH];
    logic [DW-1:0] s2h_mem [DEPTH];
    logic [DW-1:0] status, rdata;
    logic ack, h2s_full, h2s_empty, s2h_full, s2h_empty;
    logic wr_data, rd_data, wr_status, wr_irq_en;
    logic h2s_push, h2s_pop, s2h_push, s2h_pop;
    logic unused_w;

    assign unused_w = ^{wbs_sel_i[3:1], wbs_adr_i[DW-1:4], wbs_adr_i[1:0]};

    assign ack       = state_q == S_ACK;
    assign h2s_full  = h2s_cnt_q == CW'(DEPTH);
    assign h2s_empty = h2s_cnt_q == '0;
    assign s2h_full  = s2h_cnt_q == CW'(DEPTH);
    assign s2h_empty = s2h_cnt_q == '0;

    // Side effects use the request captured at IDLE->ACK, so a master that
    // drops stb/cyc during ACK still completes its transaction.
    assign wr_data   = ack & we_q & (adr_q == 2'd0);
    assign rd_data   = ack & !we_q & (adr_q == 2'd0);
    assign wr_status = ack & we_q & (adr_q == 2'd1) & sel0_q;
    assign wr_irq_en = ack & we_q & (adr_q == 2'd2) & sel0_q;

    // Full/empty come from registered counts only: no fall-through, and a
    // push into a full FIFO is refused even if a pop happens on the same edge.
    assign h2s_push = wr_data & !h2s_full;
    assign h2s_pop  = !h2s_empty & h2s_ready_i;
    assign s2h_push = s2h_valid_i & !s2h_full;
    assign s2h_pop  = rd_data & !s2h_empty;

    always_comb begin
        status        = '0;
        status[0]     = h2s_full;
        status[1]     = h2s_empty;
        status[2]     = s2h_full;
        status[3]     = s2h_empty;
        status[4]     = ovf_q;
        status[5]     = udf_q;
        status[12:8]  = 5'(h2s_cnt_q);
        status[20:16] = 5'(s2h_cnt_q);
        rdata = (adr_q == 2'd0) ? (s2h_empty ? '0 : s2h_mem[s2h_rd_q]) :
                (adr_q == 2'd1) ? status :
                (adr_q == 2'd2) ? DW'(irq_en_q) : '0;
    end

    always_comb begin
        state_d   = ack ? S_IDLE : ((wbs_stb_i & wbs_cyc_i) ? S_ACK : S_IDLE);
        adr_d     = ack ? adr_q : wbs_adr_i[3:2];
        we_d      = ack ? we_q : wbs_we_i;
        sel0_d    = ack ? sel0_q : wbs_sel_i[0];
        dat_d     = ack ? dat_q : wbs_dat_i;
        h2s_wr_d  = h2s_wr_q + AW'(h2s_push);
        h2s_rd_d  = h2s_rd_q + AW'(h2s_pop);
        s2h_wr_d  = s2h_wr_q + AW'(s2h_push);
        s2h_rd_d  = s2h_rd_q + AW'(s2h_pop);
        h2s_cnt_d = h2s_cnt_q + CW'(h2s_push) - CW'(h2s_pop);
        s2h_cnt_d = s2h_cnt_q + CW'(s2h_push) - CW'(s2h_pop);
        ovf_d     = (ovf_q & !(wr_status & dat_q[4])) | (wr_data & h2s_full);
        udf_d     = (udf_q & !(wr_status & dat_q[5])) | (rd_data & s2h_empty);
        irq_en_d  = wr_irq_en ? dat_q[0] : irq_en_q;
        irq_d     = irq_en_q & !s2h_empty;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            adr_q     <= '0;
            we_q      <= 1'b0;
            sel0_q    <= 1'b0;
            dat_q     <= '0;
            h2s_wr_q  <= '0;
            h2s_rd_q  <= '0;
            s2h_wr_q  <= '0;
            s2h_rd_q  <= '0;
            h2s_cnt_q <= '0;
            s2h_cnt_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            sel0_q    <= sel0_d;
            dat_q     <= dat_d;
            h2s_wr_q  <= h2s_wr_d;
            h2s_rd_q  <= h2s_rd_d;
            s2h_wr_q  <= s2h_wr_d;
            s2h_rd_q  <= s2h_rd_d;
            h2s_cnt_q <= h2s_cnt_d;
            s2h_cnt_q <= s2h_cnt_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && h2s_push) h2s_mem[h2s_wr_q] <= dat_q;
        if (!rst_i && s2h_push) s2h_mem[s2h_wr_q] <= s2h_data_i;
    end

    assign wbs_ack_o   = ack;
    assign wbs_dat_o   = ack ? rdata : '0;
    assign h2s_valid_o = !h2s_empty;
    assign h2s_data_o  = h2s_mem[h2s_rd_q];
    assign s2h_ready_o = !s2h_full;
    assign irq_o       = irq_q;
endmodule

// File: tb/tb_wb_mailbox.sv
// tb_wb_mailbox: directed self-checking bench for wb_mailbox (DEPTH=8, DW=32).
module tb_wb_mailbox;
    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we, h2s_ready, s2h_valid;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i, s2h_data;
    logic [31:0] dat_o, h2s_data;
    logic        ack, h2s_valid, s2h_ready, irq;
    logic [31:0] rd;
    int checks = 0;
    int errors = 0;

    wb_mailbox #(.DEPTH(8), .DW(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
        .h2s_data_o(h2s_data), .h2s_valid_o(h2s_valid), .h2s_ready_i(h2s_ready),
        .s2h_data_i(s2h_data), .s2h_valid_i(s2h_valid), .s2h_ready_o(s2h_ready),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One Wishbone transaction; entered and left 1 time unit after a rising edge.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        step();
        chk("ack_one_cycle_after_stb", {31'd0, ack}, 32'd1);
        r = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; dat_i = 32'hDEAD_BEEF;
        step();
        chk("ack_single_cycle", {31'd0, ack}, 32'd0);
    endtask

    task automatic pop_h2s();
        h2s_ready = 1'b1;
        step();
        h2s_ready = 1'b0;
    endtask

    task automatic push_s2h(input logic [31:0] d);
        s2h_valid = 1'b1; s2h_data = d;
        step();
        s2h_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 4'hF; adr = 0; dat_i = 0;
        h2s_ready = 0; s2h_valid = 0; s2h_data = 0;
        step();
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat_o", dat_o, 32'd0);
        chk("rst_h2s_valid", {31'd0, h2s_valid}, 32'd0);
        chk("rst_s2h_ready", {31'd0, s2h_ready}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Single host write becomes visible on the h2s stream.
        xfer(1'b1, 32'h0, 32'hA5A5_0001, 4'hF, rd);
        chk("h2s_valid_after_write", {31'd0, h2s_valid}, 32'd1);
        chk("h2s_data_after_write", h2s_data, 32'hA5A5_0001);
        xfer(1'b0, 32'h4, 32'h0, 4'hF, rd);
        chk("status_one_word", rd, 32'h0000_0108);
        pop_h2s();
        chk("h2s_drained", {31'd0, h2s_valid}, 32'd0);

        // Overflow: nine writes into an eight-entry FIFO.
        for (int i = 0; i < 9; i++) xfer(1'b1, 32'h0, 32'h100 + i, 4'hF, rd);
        xfer(1'b0, 32'h4, 32'h0, 4'hF, rd);
        chk("status_full_ovf", rd, 32'h0000_0819);
        for (int i = 0; i < 8; i++) begin
            chk("h2s_drain_valid", {31'd0, h2s_valid}, 32'd1);
            chk("h2s_drain_data", h2s_data, 32'h100 + i);
            pop_h2s();
        end
        chk("h2s_ninth_dropped", {31'd0, h2s_valid}, 32'd0);
        xfer(1'b1, 32'h4, 32'h10, 4'hE, rd);
        xfer(1'b0, 32'h4, 32'h0, 4'hF, rd);
        chk("w1c_ignored_sel0_low", rd, 32'h0000_001A);
        xfer(1'b1, 32'h4, 32'h10, 4'h1, rd);
        xfer(1'b0, 32'h4, 32'h0, 4'hF, rd);
        chk("status_ovf_cleared", rd, 32'h0000_000A);

        // Reserved register reads 0 whatever was written.
        xfer(1'b1, 32'hC, 32'hFFFF_FFFF, 4'hF, rd);
        xfer(1'b0, 32'hC, 32'h0, 4'hF, rd);
        chk("reserved_reads_zero", rd, 32'h0);

        // Interrupt follows IRQ_EN and s2h occupancy.
        push_s2h(32'h11);
        push_s2h(32'h22);
        chk("irq_disabled", {31'd0, irq}, 32'd0);
        xfer(1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, rd);
        step();
        chk("irq_asserted", {31'd0, irq}, 32'd1);
        xfer(1'b0, 32'h8, 32'h0, 4'hF, rd);
        chk("irq_en_readback", rd, 32'h1);
        xfer(1'b0, 32'h0, 32'h0, 4'hF, rd);
        chk("s2h_read_first", rd, 32'h11);
        xfer(1'b0, 32'h0, 32'h0, 4'hF, rd);
        chk("s2h_read_second", rd, 32'h22);
        step();
        chk("irq_cleared_after_pop", {31'd0, irq}, 32'd0);

        // Underflow on an empty s2h FIFO.
        xfer(1'b0, 32'h0, 32'h0, 4'hF, rd);
        chk("underflow_read_zero", rd, 32'h0);
        chk("dat_o_zero_idle", dat_o, 32'h0);
        xfer(1'b0, 32'h4, 32'h0, 4'hF, rd);
        chk("status_udf", rd, 32'h0000_002A);
        xfer(1'b1, 32'h4, 32'h20, 4'h1, rd);

        // Simultaneous SoC push and host pop at count 4.
        for (int i = 1; i <= 4; i++) push_s2h(32'h30 + i);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
        step();
        chk("concurrent_ack", {31'd0, ack}, 32'd1);
        chk("concurrent_read_oldest", dat_o, 32'h31);
        stb = 1'b0; cyc = 1'b0;
        s2h_valid = 1'b1; s2h_data = 32'h35;
        step();
        s2h_valid = 1'b0;
        xfer(1'b0, 32'h4, 32'h0, 4'hF, rd);
        chk("status_count_held", rd, 32'h0004_0002);
        for (int i = 2; i <= 5; i++) begin
            xfer(1'b0, 32'h0, 32'h0, 4'hF, rd);
            chk("s2h_drain_order", rd, 32'h30 + i);
        end

        // Reset during the ACK of a DATA write cancels the push.
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h0; dat_i = 32'h5555_AAAA;
        step();
        chk("rst_cancel_ack_seen", {31'd0, ack}, 32'd1);
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        step();
        rst = 1'b0;
        chk("rst_cancel_ack_low", {31'd0, ack}, 32'd0);
        chk("rst_cancel_no_push", {31'd0, h2s_valid}, 32'd0);
        chk("rst_cancel_s2h_ready", {31'd0, s2h_ready}, 32'd1);
        chk("rst_cancel_irq", {31'd0, irq}, 32'd0);
        chk("rst_cancel_dat_o", dat_o, 32'h0);
        step();
        chk("rst_cancel_still_empty", {31'd0, h2s_valid}, 32'd0);
        xfer(1'b0, 32'h4, 32'h0, 4'hF, rd);
        chk("rst_cancel_status", rd, 32'h0000_000A);
        xfer(1'b0, 32'h8, 32'h0, 4'hF, rd);
        chk("rst_cancel_irq_en", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
